// File: rtl/mem_arbiter_n_pkg.sv
// mem_arb_pkg: shared types for the mem_arbiter_n RAM arbiter.
//   state_t : arbiter FSM states (IDLE, ACCESS, WAIT, ACK)
//   op_t    : registered transaction kind (READ, WRITE)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    ACK    = 2'd3
  } state_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/mem_arbiter_n_if.sv
// mem_arbiter_n_if: core-side request bus plus RAM-side bus of the arbiter.
//   slave  : arbiter view (takes rden/wren/Address/Din/RAMq, drives
//            acq/Dq/RAMAddress/RAMDin/RAMwren/busy)
//   master : core array + RAM view (the reverse directions)
interface mem_arbiter_n_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8
);
  logic [NUM_PORTS-1:0]        rden;
  logic [NUM_PORTS-1:0]        wren;
  logic [NUM_PORTS*ADDR_W-1:0] Address;
  logic [NUM_PORTS*DATA_W-1:0] Din;
  logic [DATA_W-1:0]           RAMq;
  logic [NUM_PORTS-1:0]        acq;
  logic [NUM_PORTS*DATA_W-1:0] Dq;
  logic [ADDR_W-1:0]           RAMAddress;
  logic [DATA_W-1:0]           RAMDin;
  logic                        RAMwren;
  logic                        busy;

  modport slave (
    input  rden, wren, Address, Din, RAMq,
    output acq, Dq, RAMAddress, RAMDin, RAMwren, busy
  );

  modport master (
    output rden, wren, Address, Din, RAMq,
    input  acq, Dq, RAMAddress, RAMDin, RAMwren, busy
  );
endinterface

// File: rtl/mem_arbiter_n_rr_pick.sv
// mem_rr_pick: combinational rotating-priority picker.
//   req   : request vector
//   ptr   : port with highest priority this round
//   grant : one-hot of the first requesting port at or after ptr (with wrap)
//   idx   : binary index of that port (0 when no request)
module mem_rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PTR_W-1:0]     idx
);

  logic             found;
  logic [PTR_W:0]   pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      // One extra bit holds ptr+i before the wrap back into 0..NUM_PORTS-1.
      pos = {1'b0, ptr} + (PTR_W+1)'(i);
      if (pos >= (PTR_W+1)'(NUM_PORTS)) pos = pos - (PTR_W+1)'(NUM_PORTS);
      if (!found && req[pos[PTR_W-1:0]]) begin
        found                 = 1'b1;
        grant[pos[PTR_W-1:0]] = 1'b1;
        idx                   = pos[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: round-robin arbiter sharing one single-port synchronous RAM
// among NUM_PORTS cores. One transaction takes IDLE->ACCESS->WAIT->ACK.
//   CLK, rst : clock, synchronous active-high reset
//   bus      : mem_arbiter_n_if.slave (per-port rden/wren/Address/Din in,
//              acq/Dq out; RAMq in, RAMAddress/RAMDin/RAMwren out; busy out)
// Optional feature: define MEMARB_BROADCAST_EN to serve identical-address
// reads from several ports in one RAM access.
module mem_arbiter_n
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8
) (
  input  logic              CLK,
  input  logic              rst,
  mem_arbiter_n_if.slave    bus
);

  localparam int PTR_W = $clog2(NUM_PORTS);

  state_t                      state, state_nxt;
  op_t                         op;
  logic [PTR_W-1:0]            ptr, sel;
  logic [NUM_PORTS-1:0]        mask, gset, gset_nxt;
  logic [NUM_PORTS-1:0]        eligible, win_oh;
  logic [PTR_W-1:0]            win_idx;
  logic                        any_req, win_wr;
  logic [ADDR_W-1:0]           win_addr;
  logic [ADDR_W-1:0]           ram_addr_q;
  logic [DATA_W-1:0]           ram_din_q;
  logic                        ram_wren_q;
  logic [NUM_PORTS*DATA_W-1:0] dq_q;

  // Ports acked in the previous ACK are masked for one IDLE cycle.
  assign eligible = (bus.rden | bus.wren) & ~mask;
  assign any_req  = |eligible;

  mem_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_pick (
    .req   (eligible),
    .ptr   (ptr),
    .grant (win_oh),
    .idx   (win_idx)
  );

  // A simultaneous read+write request on one port is served as a write.
  assign win_wr   = bus.wren[win_idx];
  assign win_addr = bus.Address[win_idx*ADDR_W +: ADDR_W];

  always_comb begin
    gset_nxt = win_oh;
`ifdef MEMARB_BROADCAST_EN
    if (!win_wr) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (bus.rden[p] && !bus.wren[p] && !mask[p] &&
            bus.Address[p*ADDR_W +: ADDR_W] == win_addr)
          gset_nxt[p] = 1'b1;
      end
    end
`endif
  end

  // State register
  always_ff @(posedge CLK) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = WAIT;
      WAIT:    state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    bus.busy = (state != IDLE);
    bus.acq  = (state == ACK) ? gset : '0;
  end

  // Grant capture, RAM drive, read-data capture, pointer and cooldown mask
  always_ff @(posedge CLK) begin
    if (rst) begin
      ptr        <= '0;
      mask       <= '0;
      sel        <= '0;
      op         <= READ;
      gset       <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_wren_q <= 1'b0;
      dq_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          mask <= '0;
          if (any_req) begin
            sel        <= win_idx;
            op         <= win_wr ? WRITE : READ;
            gset       <= gset_nxt;
            ram_addr_q <= win_addr;
            ram_din_q  <= bus.Din[win_idx*DATA_W +: DATA_W];
            ram_wren_q <= win_wr;
          end
        end
        ACCESS: ram_wren_q <= 1'b0;
        WAIT: begin
          if (op == READ) begin
            for (int p = 0; p < NUM_PORTS; p++)
              if (gset[p]) dq_q[p*DATA_W +: DATA_W] <= bus.RAMq;
          end
        end
        ACK: begin
          ptr  <= (sel == PTR_W'(NUM_PORTS-1)) ? '0 : sel + 1'b1;
          mask <= gset;
        end
        default: ;
      endcase
    end
  end

  assign bus.RAMAddress = ram_addr_q;
  assign bus.RAMDin     = ram_din_q;
  assign bus.RAMwren    = ram_wren_q;
  assign bus.Dq         = dq_q;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb_mem_arbiter_n: directed timing checks followed by randomized request
// rounds checked against a transaction-level round-robin model.
module tb_mem_arbiter_n;

  localparam int NP = 4;
`ifdef MEMARB_BROADCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic CLK = 1'b0;
  logic rst;
  logic ram_init;
  always #5 CLK = ~CLK;

  mem_arbiter_n_if #(.NUM_PORTS(NP), .ADDR_W(8), .DATA_W(8)) bus ();

  mem_arbiter_n #(.NUM_PORTS(NP), .ADDR_W(8), .DATA_W(8)) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous RAM with registered read data.
  logic [7:0] ram_mem [256];
  logic [7:0] ram_q;
  always @(posedge CLK) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 8'(i) ^ 8'h5A;
      ram_mem[8'h10] <= 8'hA5;
    end else if (bus.RAMwren) begin
      ram_mem[bus.RAMAddress] <= bus.RAMDin;
    end
    ram_q <= ram_mem[bus.RAMAddress];
  end
  assign bus.RAMq = ram_q;

  int wr_pulses = 0;
  always @(negedge CLK) if (bus.RAMwren) wr_pulses++;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  logic [7:0]  mmem [256];
  int          mptr;
  logic [31:0] mdq;
  logic [3:0]  ack_log [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    rst = 1'b1;
    bus.rden = '0;
    bus.wren = '0;
    @(negedge CLK);
    rst = 1'b0;
    mptr = 0;
    mdq = '0;
  endtask

  // Hold the given requests, predict the ack sequence from the round-robin
  // rules, and drop each port's request as its acq arrives.
  task automatic run_round(input logic [3:0] rd, input logic [3:0] wr,
                           input logic [31:0] addr, input logic [31:0] din);
    logic [3:0]  pend, s, got, eset_q[$];
    logic [31:0] edq_q[$];
    int          w, p, nwr, wr0, n;
    pend = rd | wr;
    nwr = 0;
    while (pend != 0) begin
      w = -1;
      for (int i = 0; i < NP; i++) begin
        p = (mptr + i) % NP;
        if (w < 0 && pend[p]) w = p;
      end
      s = '0;
      s[w] = 1'b1;
      if (wr[w]) begin
        mmem[addr[w*8 +: 8]] = din[w*8 +: 8];
        nwr++;
      end else begin
        if (BCAST)
          for (int q = 0; q < NP; q++)
            if (pend[q] && rd[q] && !wr[q] && addr[q*8 +: 8] == addr[w*8 +: 8]) s[q] = 1'b1;
        for (int q = 0; q < NP; q++)
          if (s[q]) mdq[q*8 +: 8] = mmem[addr[q*8 +: 8]];
      end
      mptr = (w + 1) % NP;
      pend &= ~s;
      eset_q.push_back(s);
      edq_q.push_back(mdq);
    end

    wr0 = wr_pulses;
    bus.Address = addr;
    bus.Din = din;
    bus.rden = rd;
    bus.wren = wr;
    foreach (eset_q[k]) begin
      n = 0;
      do begin
        @(negedge CLK);
        n++;
      end while (bus.acq == '0 && n < 20);
      got = bus.acq;
      ack_log.push_back(got);
      check("ack_set", {28'd0, got}, {28'd0, eset_q[k]});
      check("dq", bus.Dq, edq_q[k]);
      if (got == '0) got = eset_q[k];
      bus.rden &= ~got;
      bus.wren &= ~got;
    end
    step(2);
    check("idle_after_round", {31'd0, bus.busy}, 32'd0);
    check("wren_pulses", 32'(wr_pulses - wr0), 32'(nwr));
  endtask

  initial begin
    logic [3:0]  rd, wr;
    logic [31:0] addr, din;

    rst = 1'b1;
    ram_init = 1'b1;
    bus.rden = '0;
    bus.wren = '0;
    bus.Address = '0;
    bus.Din = '0;
    for (int i = 0; i < 256; i++) mmem[i] = 8'(i) ^ 8'h5A;
    mmem[8'h10] = 8'hA5;
    step(3);
    ram_init = 1'b0;
    rst = 1'b0;
    mptr = 0;
    mdq = '0;
    step(1);

    // Reset state
    check("rst_acq", {28'd0, bus.acq}, 32'd0);
    check("rst_dq", bus.Dq, 32'd0);
    check("rst_ram", {15'd0, bus.RAMwren, bus.RAMDin, bus.RAMAddress}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);

    // Port 2 reads 0x10 (RAM word A5)
    bus.Address[2*8 +: 8] = 8'h10;
    bus.rden[2] = 1'b1;
    step(1);
    check("rd_addr_c1", {24'd0, bus.RAMAddress}, 32'h10);
    check("rd_wren_c1", {31'd0, bus.RAMwren}, 32'd0);
    check("rd_acq_c1", {28'd0, bus.acq}, 32'd0);
    step(1);
    check("rd_acq_c2", {28'd0, bus.acq}, 32'd0);
    step(1);
    check("rd_acq_c3", {28'd0, bus.acq}, 32'h4);
    check("rd_dq2", {24'd0, bus.Dq[2*8 +: 8]}, 32'hA5);
    bus.rden[2] = 1'b0;
    step(1);
    check("rd_acq_c4", {28'd0, bus.acq}, 32'd0);
    step(2);

    // Port 1 writes 3C to 0x20, then port 0 reads it back
    bus.Address[1*8 +: 8] = 8'h20;
    bus.Din[1*8 +: 8] = 8'h3C;
    bus.wren[1] = 1'b1;
    step(1);
    check("wr_c1", {15'd0, bus.RAMwren, bus.RAMDin, bus.RAMAddress}, {15'd0, 1'b1, 8'h3C, 8'h20});
    step(1);
    check("wr_wren_c2", {31'd0, bus.RAMwren}, 32'd0);
    step(1);
    check("wr_acq", {28'd0, bus.acq}, 32'h2);
    bus.wren[1] = 1'b0;
    step(2);
    bus.Address[0*8 +: 8] = 8'h20;
    bus.rden[0] = 1'b1;
    step(3);
    check("rdback_acq", {28'd0, bus.acq}, 32'h1);
    check("rdback_dq0", {24'd0, bus.Dq[0*8 +: 8]}, 32'h3C);
    bus.rden[0] = 1'b0;
    step(2);

    // Ports 0, 1, 3 hold reads from reset: order 0, 1, 3, 0
    @(negedge CLK);
    rst = 1'b1;
    bus.Address = {8'h43, 8'h42, 8'h41, 8'h40};
    bus.rden = 4'b1011;
    @(negedge CLK);
    rst = 1'b0;
    step(3);
    check("rr_ack0", {28'd0, bus.acq}, 32'h1);
    step(4);
    check("rr_ack1", {28'd0, bus.acq}, 32'h2);
    step(4);
    check("rr_ack2", {28'd0, bus.acq}, 32'h8);
    step(4);
    check("rr_ack3", {28'd0, bus.acq}, 32'h1);
    check("rr_dq", bus.Dq, {8'h43 ^ 8'h5A, 8'h00, 8'h41 ^ 8'h5A, 8'h40 ^ 8'h5A});
    bus.rden = '0;
    step(2);

    // Port 0 read+write together: one write, one acq, Dq[0] unchanged
    bus.Address[0*8 +: 8] = 8'h30;
    bus.Din[0*8 +: 8] = 8'h77;
    bus.rden[0] = 1'b1;
    bus.wren[0] = 1'b1;
    step(1);
    check("rw_c1", {15'd0, bus.RAMwren, bus.RAMDin, bus.RAMAddress}, {15'd0, 1'b1, 8'h77, 8'h30});
    step(1);
    check("rw_wren_c2", {31'd0, bus.RAMwren}, 32'd0);
    step(1);
    check("rw_acq", {28'd0, bus.acq}, 32'h1);
    check("rw_dq0", {24'd0, bus.Dq[0*8 +: 8]}, {24'd0, 8'h40 ^ 8'h5A});
    bus.rden[0] = 1'b0;
    bus.wren[0] = 1'b0;
    step(1);
    check("rw_single_acq", {28'd0, bus.acq}, 32'd0);
    step(1);
    bus.Address[2*8 +: 8] = 8'h30;
    bus.rden[2] = 1'b1;
    step(3);
    check("rw_readback", {20'd0, bus.acq, bus.Dq[2*8 +: 8]}, {20'd0, 4'h4, 8'h77});
    bus.rden[2] = 1'b0;
    step(2);

    // Reset during WAIT of a port 2 read
    bus.Address[2*8 +: 8] = 8'h10;
    bus.rden[2] = 1'b1;
    step(2);
    rst = 1'b1;
    bus.rden = '0;
    step(1);
    check("wrst_acq", {28'd0, bus.acq}, 32'd0);
    check("wrst_busy", {31'd0, bus.busy}, 32'd0);
    check("wrst_dq", bus.Dq, 32'd0);
    check("wrst_ram", {15'd0, bus.RAMwren, bus.RAMDin, bus.RAMAddress}, 32'd0);
    rst = 1'b0;
    bus.Address = {8'h43, 8'h42, 8'h41, 8'h41};
    bus.rden = 4'b1001;
    step(3);
    check("wrst_ptr0", {28'd0, bus.acq}, 32'h1);
    bus.rden[0] = 1'b0;
    step(4);
    check("wrst_next", {28'd0, bus.acq}, 32'h8);
    bus.rden = '0;
    step(2);

    // Same-address reads on ports 0 and 2, port 1 on another address
    do_reset();
    ack_log.delete();
    run_round(4'b0111, 4'b0000, {8'h00, 8'h05, 8'h06, 8'h05}, 32'd0);
`ifdef MEMARB_BROADCAST_EN
    check("bc_first", {28'd0, ack_log[0]}, 32'h5);
    check("bc_second", {28'd0, ack_log[1]}, 32'h2);
`else
    check("nb_first", {28'd0, ack_log[0]}, 32'h1);
    check("nb_second", {28'd0, ack_log[1]}, 32'h2);
    check("nb_third", {28'd0, ack_log[2]}, 32'h4);
`endif

    // Randomized rounds
    for (int r = 0; r < 24; r++) begin
      rd = '0;
      wr = '0;
      for (int p = 0; p < NP; p++) begin
        case ($urandom_range(0, 3))
          1: rd[p] = 1'b1;
          2: wr[p] = 1'b1;
          3: begin rd[p] = 1'b1; wr[p] = 1'b1; end
          default: ;
        endcase
        addr[p*8 +: 8] = 8'($urandom_range(0, 7));
        din[p*8 +: 8]  = 8'($urandom_range(0, 255));
      end
      if ((rd | wr) == '0) rd[$urandom_range(0, 3)] = 1'b1;
      run_round(rd, wr, addr, din);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
